lift_scan_ctrl: RTL and testbench
=================================

Name: lift_scan_ctrl

Overview:
- Parametrised multi-floor elevator car controller; next generation of the team's single-car lift FSM.
- Latches cab and hall (up/down) requests into pending registers and serves them with a SCAN (collective up/down) policy.
- Models per-floor travel time and a door dwell timer.
- Sits between the floor/cab button decoders and the car position/door indicator logic.

Parameters:
- FLOORS, 8, number of floors (min 2); floors numbered 0..FLOORS-1.
- FLOOR_W, 3, width of the floor index; must satisfy 2^FLOOR_W >= FLOORS.
- MOVE_CYCLES, 16, clock cycles to travel one floor (min 1).
- DOOR_CYCLES, 32, clock cycles the door stays open (min 1).
- RESET_FLOOR, 0, car position after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cab_req  in  FLOORS  cab button per floor; a cycle high latches the request
- hall_up  in  FLOORS  hall up-call per floor; bit FLOORS-1 is ignored
- hall_dn  in  FLOORS  hall down-call per floor; bit 0 is ignored
- door_hold  in  1  level; while high in DOOR, restarts the dwell timer
- floor_o  out  FLOOR_W  current car floor
- dir_o  out  2  00 none, 01 up, 10 down
- moving_o  out  1  high in MOVE
- door_open_o  out  1  high in DOOR
- arrive_o  out  1  one-cycle pulse on each floor change
- busy_o  out  1  high when state != IDLE or any request is pending
- pending_o  out  FLOORS  OR of cab, up and down pending bits per floor

Behaviour:
- Reset (async):
  - state IDLE, floor_o = RESET_FLOOR, dir_o = 00.
  - moving_o, door_open_o, arrive_o, busy_o = 0.
  - All pending registers and timers cleared.
- Latching:
  - Each cycle: pend_cab |= cab_req, pend_up |= hall_up (top bit forced 0), pend_dn |= hall_dn (bit 0 forced 0).
  - When a set and a clear hit the same bit in the same cycle, the clear wins only if the car serves that floor in that cycle. Otherwise the set wins.
- Helpers: above = any pending bit at floors > floor_o; below = any pending bit at floors < floor_o.
- IDLE:
  - Pending at floor_o: go to DOOR. Clear pend_cab[f], pend_up[f] and pend_dn[f]. dir_o stays 00.
  - Else if above: go to MOVE, dir up. Else if below: go to MOVE, dir down. Up wins a tie.
  - A request latched at edge k produces moving_o = 1 after edge k+1.
- MOVE:
  - The timer loads MOVE_CYCLES-1 on entry and counts down.
  - At 0: floor_o ±1 and arrive_o pulses for one cycle, both on the same edge.
  - Then evaluate the stop condition at the new floor f. Stop when pend_cab[f] is set, or the hall call in the current direction is set, or there are no requests further ahead (that is, only the opposite hall call at f is pending).
  - Stop: go to DOOR and clear pend_cab[f] and the hall bit served. If nothing lies ahead, also clear the opposite hall bit.
  - No stop: reload the timer and continue.
  - The car never passes floor 0 or FLOORS-1.
- DOOR:
  - The timer loads DOOR_CYCLES-1 on entry and reloads while door_hold = 1.
  - A new cab_req[f], or a new hall call at f in the current direction (either call when dir = 00), is cleared and reloads the timer.
  - At 0 with door_hold = 0:
    - Requests ahead in dir: go to MOVE, same direction.
    - Else requests on the other side: go to MOVE, reversed.
    - Else: go to IDLE, dir_o = 00.
- Outputs are registered and derived from the state and registers only; there is no combinational input-to-output path.
- Reset asserted mid-MOVE or mid-DOOR: the car snaps to RESET_FLOOR and all requests are dropped.

Test Plan:
Use FLOORS=8, MOVE_CYCLES=4, DOOR_CYCLES=6, RESET_FLOOR=0.
1. Release reset -> floor_o=0, dir_o=00, busy_o=0, pending_o=0, door_open_o=0.
2. Pulse cab_req[5] at floor 0 -> MOVE one edge later, dir_o=01. floor_o steps 1..5 every 4 cycles with an arrive_o pulse each step. door_open_o high 6 cycles, then IDLE, dir_o=00, busy_o=0.
3. Car going up to cab 6; hall_up[4] and hall_dn[3] pulsed while at floor 2 -> stops at 4 (clears up bit), then 6, then reverses (dir_o=10) and stops at 3. pending_o=0 at end.
4. Door open at floor 3: hold door_hold for 10 cycles -> door stays open for the 10 cycles plus 6 more. A cab_req[3] pulse during the dwell restarts the 6-cycle count.
5. hall_dn[0] and hall_up[7] pulsed in IDLE at floor 4 -> ignored, pending_o=0, busy_o=0. hall_up[2] and hall_dn[6] together -> car goes down first? No: up wins the tie -> car goes up to 6, then serves 2.
6. Assert rst_n low during MOVE between floors 3 and 4 with pending cab 7 -> immediately floor_o=0, moving_o=0, pending_o=0. After release, stays IDLE.

Source files
------------

// File: rtl/lift_scan_ctrl.sv
// Single-car elevator controller: latches cab/hall requests and serves them
// with a SCAN (collective up/down) policy, modelling floor travel and door dwell.
module lift_scan_ctrl #(
  parameter int FLOORS      = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 16,
  parameter int DOOR_CYCLES = 32,
  parameter int RESET_FLOOR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOORS-1:0]  cab_req,
  input  logic [FLOORS-1:0]  hall_up,
  input  logic [FLOORS-1:0]  hall_dn,
  input  logic               door_hold,
  output logic [FLOOR_W-1:0] floor_o,
  output logic [1:0]         dir_o,
  output logic               moving_o,
  output logic               door_open_o,
  output logic               arrive_o,
  output logic               busy_o,
  output logic [FLOORS-1:0]  pending_o
);

  localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);
  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t             state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [1:0]         dir_q, dir_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [FLOORS-1:0]  pend_cab_q, pend_cab_d;
  logic [FLOORS-1:0]  pend_up_q, pend_up_d;
  logic [FLOORS-1:0]  pend_dn_q, pend_dn_d;
  logic               arrive_q, arrive_d;

  logic [FLOORS-1:0]  pend_all, cur_oh, nf_oh, hall_fwd;
  logic [FLOORS-1:0]  set_up, set_dn, clr_cab, clr_up, clr_dn;
  logic [FLOOR_W-1:0] nf;
  logic               above, below, ahead_nf;

  function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i == int'(f));
    return m;
  endfunction

  function automatic logic [FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] m;
    for (int i = 0; i < FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      floor_q    <= FLOOR_W'(RESET_FLOOR);
      dir_q      <= DIR_NONE;
      timer_q    <= '0;
      pend_cab_q <= '0;
      pend_up_q  <= '0;
      pend_dn_q  <= '0;
      arrive_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      floor_q    <= floor_d;
      dir_q      <= dir_d;
      timer_q    <= timer_d;
      pend_cab_q <= pend_cab_d;
      pend_up_q  <= pend_up_d;
      pend_dn_q  <= pend_dn_d;
      arrive_q   <= arrive_d;
    end
  end

  always_comb begin
    pend_all = pend_cab_q | pend_up_q | pend_dn_q;
    cur_oh   = onehot(floor_q);
    above    = |(pend_all & above_mask(floor_q));
    below    = |(pend_all & below_mask(floor_q));
    set_up   = hall_up;
    set_up[FLOORS-1] = 1'b0;
    set_dn   = hall_dn;
    set_dn[0] = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    arrive_d = 1'b0;
    clr_cab  = '0;
    clr_up   = '0;
    clr_dn   = '0;
    nf       = floor_q;
    nf_oh    = '0;
    hall_fwd = '0;
    ahead_nf = 1'b0;
    case (state_q)
      IDLE: begin
        if (|(pend_all & cur_oh)) begin
          state_d = DOOR;
          timer_d = DOOR_LOAD;
          clr_cab = cur_oh;
          clr_up  = cur_oh;
          clr_dn  = cur_oh;
        end else if (above) begin
          state_d = MOVE;
          dir_d   = DIR_UP;
          timer_d = MOVE_LOAD;
        end else if (below) begin
          state_d = MOVE;
          dir_d   = DIR_DN;
          timer_d = MOVE_LOAD;
        end
      end
      MOVE: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          // Stop decision is taken against the floor being arrived at this edge.
          nf       = (dir_q == DIR_DN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
          nf_oh    = onehot(nf);
          hall_fwd = (dir_q == DIR_DN) ? pend_dn_q : pend_up_q;
          ahead_nf = (dir_q == DIR_DN) ? |(pend_all & below_mask(nf))
                                       : |(pend_all & above_mask(nf));
          floor_d  = nf;
          arrive_d = 1'b1;
          if (|(pend_cab_q & nf_oh) || |(hall_fwd & nf_oh) || !ahead_nf) begin
            state_d = DOOR;
            timer_d = DOOR_LOAD;
            clr_cab = nf_oh;
            if (!ahead_nf) begin
              clr_up = nf_oh;
              clr_dn = nf_oh;
            end else if (dir_q == DIR_DN) begin
              clr_dn = nf_oh;
            end else begin
              clr_up = nf_oh;
            end
          end else begin
            timer_d = MOVE_LOAD;
          end
        end
      end
      DOOR: begin
        // Calls arriving at the open floor are absorbed and keep the door open.
        clr_cab = cab_req & cur_oh;
        clr_up  = (dir_q != DIR_DN) ? (set_up & cur_oh) : '0;
        clr_dn  = (dir_q != DIR_UP) ? (set_dn & cur_oh) : '0;
        if (door_hold || |(clr_cab | clr_up | clr_dn)) begin
          timer_d = DOOR_LOAD;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (dir_q == DIR_UP && above) begin
          state_d = MOVE;
          timer_d = MOVE_LOAD;
        end else if (dir_q == DIR_DN && below) begin
          state_d = MOVE;
          timer_d = MOVE_LOAD;
        end else if (above) begin
          state_d = MOVE;
          dir_d   = DIR_UP;
          timer_d = MOVE_LOAD;
        end else if (below) begin
          state_d = MOVE;
          dir_d   = DIR_DN;
          timer_d = MOVE_LOAD;
        end else begin
          state_d = IDLE;
          dir_d   = DIR_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        dir_d   = DIR_NONE;
      end
    endcase
    pend_cab_d = (pend_cab_q | cab_req) & ~clr_cab;
    pend_up_d  = (pend_up_q  | set_up)  & ~clr_up;
    pend_dn_d  = (pend_dn_q  | set_dn)  & ~clr_dn;
  end

  always_comb begin
    floor_o     = floor_q;
    dir_o       = dir_q;
    moving_o    = (state_q == MOVE);
    door_open_o = (state_q == DOOR);
    arrive_o    = arrive_q;
    pending_o   = pend_all;
    busy_o      = (state_q != IDLE) || (|pend_all);
  end

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Scenario bench for lift_scan_ctrl: a negedge monitor pops expected arrival
// and stop floors queued by each scenario task; tasks check timing inline.
module tb_lift_scan_ctrl;
  localparam int FLOORS = 8;
  localparam int FLOOR_W = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [FLOORS-1:0]  cab_req = '0, hall_up = '0, hall_dn = '0;
  logic               door_hold = 1'b0;
  logic [FLOOR_W-1:0] floor_o;
  logic [1:0]         dir_o;
  logic               moving_o, door_open_o, arrive_o, busy_o;
  logic [FLOORS-1:0]  pending_o;

  int checks = 0;
  int errors = 0;
  logic [FLOOR_W-1:0] arr_q[$];
  logic [FLOOR_W-1:0] stop_q[$];
  logic [FLOOR_W-1:0] mon_exp;
  logic               door_prev = 1'b0;

  lift_scan_ctrl #(.FLOORS(8), .FLOOR_W(3), .MOVE_CYCLES(4), .DOOR_CYCLES(6), .RESET_FLOOR(0)) dut (
    .clk(clk), .rst_n(rst_n), .cab_req(cab_req), .hall_up(hall_up), .hall_dn(hall_dn),
    .door_hold(door_hold), .floor_o(floor_o), .dir_o(dir_o), .moving_o(moving_o),
    .door_open_o(door_open_o), .arrive_o(arrive_o), .busy_o(busy_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (arrive_o === 1'b1) begin
        checks++;
        if (arr_q.size() == 0) begin
          errors++; $display("FAIL arrive_seq: arrival at floor %0d, required none", floor_o);
        end else begin
          mon_exp = arr_q.pop_front();
          if (floor_o !== mon_exp) begin errors++; $display("FAIL arrive_seq: floor %0d, required %0d", floor_o, mon_exp); end
        end
      end
      if (door_open_o === 1'b1 && door_prev === 1'b0) begin
        checks++;
        if (stop_q.size() == 0) begin
          errors++; $display("FAIL stop_seq: door opened at floor %0d, required none", floor_o);
        end else begin
          mon_exp = stop_q.pop_front();
          if (floor_o !== mon_exp) begin errors++; $display("FAIL stop_seq: floor %0d, required %0d", floor_o, mon_exp); end
        end
      end
    end
    door_prev = door_open_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    cab_req = '0; hall_up = '0; hall_dn = '0; door_hold = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    arr_q.delete(); stop_q.delete();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick(); tick(); tick();
    checks++; if (floor_o !== 3'd0) begin errors++; $display("FAIL rst_floor: got %0d required 0", floor_o); end
    checks++; if (dir_o !== 2'b00) begin errors++; $display("FAIL rst_dir: got %b required 00", dir_o); end
    checks++; if ({moving_o, door_open_o, arrive_o, busy_o} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b required 0000", {moving_o, door_open_o, arrive_o, busy_o}); end
    checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL rst_pending: got %h required 00", pending_o); end
    rst_n = 1'b1;
    tick(); tick();
    checks++; if ({busy_o, moving_o, door_open_o, floor_o} !== 6'b000_000) begin errors++; $display("FAIL rst_release_idle: got %b required 000000", {busy_o, moving_o, door_open_o, floor_o}); end
  endtask

  task automatic test_single_trip();
    int n;
    cab_req = 8'h20;
    for (int f = 1; f <= 5; f++) arr_q.push_back(3'(f));
    stop_q.push_back(3'd5);
    tick(); cab_req = '0;
    checks++; if ({pending_o, moving_o, busy_o} !== {8'h20, 1'b0, 1'b1}) begin errors++; $display("FAIL trip_latch: pending=%h moving=%b busy=%b required 20 0 1", pending_o, moving_o, busy_o); end
    tick();
    checks++; if ({moving_o, dir_o, floor_o} !== {1'b1, 2'b01, 3'd0}) begin errors++; $display("FAIL trip_start: moving=%b dir=%b floor=%0d required 1 01 0", moving_o, dir_o, floor_o); end
    for (int s = 1; s <= 5; s++) begin
      repeat (4) tick();
      checks++; if ({floor_o, arrive_o} !== {3'(s), 1'b1}) begin errors++; $display("FAIL trip_step: floor=%0d arrive=%b required %0d 1", floor_o, arrive_o, s); end
    end
    checks++; if ({door_open_o, moving_o} !== 2'b10) begin errors++; $display("FAIL trip_door_open: door=%b moving=%b required 1 0", door_open_o, moving_o); end
    n = 0;
    while (door_open_o === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n != 6) begin errors++; $display("FAIL trip_door_len: got %0d cycles required 6", n); end
    checks++; if ({dir_o, busy_o, floor_o, pending_o} !== {2'b00, 1'b0, 3'd5, 8'h00}) begin errors++; $display("FAIL trip_idle: dir=%b busy=%b floor=%0d pending=%h required 00 0 5 00", dir_o, busy_o, floor_o, pending_o); end
    checks++; if (arr_q.size() + stop_q.size() != 0) begin errors++; $display("FAIL trip_queues: %0d left required 0", arr_q.size() + stop_q.size()); end
  endtask

  task automatic test_collective();
    int n;
    do_reset();
    cab_req = 8'h40;
    for (int f = 1; f <= 6; f++) arr_q.push_back(3'(f));
    tick(); cab_req = '0;
    n = 0;
    while (floor_o !== 3'd2 && n < 200) begin n++; tick(); end
    checks++; if (floor_o !== 3'd2) begin errors++; $display("FAIL coll_reach2: floor=%0d required 2", floor_o); end
    hall_up = 8'h10; hall_dn = 8'h08;
    arr_q.push_back(3'd5); arr_q.push_back(3'd4); arr_q.push_back(3'd3);
    stop_q.push_back(3'd4); stop_q.push_back(3'd6); stop_q.push_back(3'd3);
    tick(); hall_up = '0; hall_dn = '0;
    checks++; if (pending_o !== 8'h58) begin errors++; $display("FAIL coll_latch: pending=%h required 58", pending_o); end
    n = 0;
    while (door_open_o !== 1'b1 && n < 200) begin n++; tick(); end
    checks++; if ({floor_o, pending_o} !== {3'd4, 8'h48}) begin errors++; $display("FAIL coll_stop4: floor=%0d pending=%h required 4 48", floor_o, pending_o); end
    n = 0;
    while (!(door_open_o === 1'b1 && floor_o === 3'd6) && n < 200) begin n++; tick(); end
    checks++; if ({floor_o, pending_o} !== {3'd6, 8'h08}) begin errors++; $display("FAIL coll_stop6: floor=%0d pending=%h required 6 08", floor_o, pending_o); end
    n = 0;
    while (moving_o !== 1'b1 && n < 200) begin n++; tick(); end
    checks++; if ({dir_o, floor_o} !== {2'b10, 3'd6}) begin errors++; $display("FAIL coll_reverse: dir=%b floor=%0d required 10 6", dir_o, floor_o); end
    n = 0;
    while (busy_o !== 1'b0 && n < 400) begin n++; tick(); end
    checks++; if ({floor_o, pending_o, dir_o} !== {3'd3, 8'h00, 2'b00}) begin errors++; $display("FAIL coll_end: floor=%0d pending=%h dir=%b required 3 00 00", floor_o, pending_o, dir_o); end
    checks++; if (arr_q.size() + stop_q.size() != 0) begin errors++; $display("FAIL coll_queues: %0d left required 0", arr_q.size() + stop_q.size()); end
  endtask

  task automatic test_door_hold();
    int n;
    cab_req = 8'h08; stop_q.push_back(3'd3);
    tick(); cab_req = '0;
    tick();
    checks++; if ({door_open_o, floor_o, dir_o} !== {1'b1, 3'd3, 2'b00}) begin errors++; $display("FAIL hold_open: door=%b floor=%0d dir=%b required 1 3 00", door_open_o, floor_o, dir_o); end
    door_hold = 1'b1;
    repeat (10) tick();
    checks++; if (door_open_o !== 1'b1) begin errors++; $display("FAIL hold_during: door=%b required 1", door_open_o); end
    door_hold = 1'b0;
    n = 0;
    while (door_open_o === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n != 6) begin errors++; $display("FAIL hold_after: got %0d cycles required 6", n); end
    cab_req = 8'h08; stop_q.push_back(3'd3);
    tick(); cab_req = '0;
    tick(); tick(); tick();
    cab_req = 8'h08;
    tick(); cab_req = '0;
    checks++; if ({door_open_o, pending_o} !== {1'b1, 8'h00}) begin errors++; $display("FAIL hold_cab_absorb: door=%b pending=%h required 1 00", door_open_o, pending_o); end
    n = 0;
    while (door_open_o === 1'b1 && n < 100) begin n++; tick(); end
    checks++; if (n != 6) begin errors++; $display("FAIL hold_cab_restart: got %0d cycles required 6", n); end
    checks++; if ({busy_o, stop_q.size() == 0} !== 2'b01) begin errors++; $display("FAIL hold_end: busy=%b stops_left=%0d required 0 0", busy_o, stop_q.size()); end
  endtask

  task automatic test_ignored_and_tie();
    int n;
    do_reset();
    cab_req = 8'h10;
    for (int f = 1; f <= 4; f++) arr_q.push_back(3'(f));
    stop_q.push_back(3'd4);
    tick(); cab_req = '0;
    n = 0;
    while (busy_o !== 1'b0 && n < 200) begin n++; tick(); end
    checks++; if ({floor_o, busy_o} !== {3'd4, 1'b0}) begin errors++; $display("FAIL tie_at4: floor=%0d busy=%b required 4 0", floor_o, busy_o); end
    hall_dn = 8'h01; hall_up = 8'h80;
    tick(); hall_dn = '0; hall_up = '0;
    checks++; if ({pending_o, busy_o} !== {8'h00, 1'b0}) begin errors++; $display("FAIL ignored_bits: pending=%h busy=%b required 00 0", pending_o, busy_o); end
    repeat (3) tick();
    checks++; if ({moving_o, door_open_o} !== 2'b00) begin errors++; $display("FAIL ignored_idle: moving=%b door=%b required 0 0", moving_o, door_open_o); end
    hall_up = 8'h04; hall_dn = 8'h40;
    arr_q.push_back(3'd5); arr_q.push_back(3'd6);
    for (int f = 5; f >= 2; f--) arr_q.push_back(3'(f));
    stop_q.push_back(3'd6); stop_q.push_back(3'd2);
    tick(); hall_up = '0; hall_dn = '0;
    checks++; if (pending_o !== 8'h44) begin errors++; $display("FAIL tie_latch: pending=%h required 44", pending_o); end
    tick();
    checks++; if ({moving_o, dir_o} !== {1'b1, 2'b01}) begin errors++; $display("FAIL tie_up_first: moving=%b dir=%b required 1 01", moving_o, dir_o); end
    n = 0;
    while (busy_o !== 1'b0 && n < 400) begin n++; tick(); end
    checks++; if ({floor_o, pending_o} !== {3'd2, 8'h00}) begin errors++; $display("FAIL tie_end: floor=%0d pending=%h required 2 00", floor_o, pending_o); end
    checks++; if (arr_q.size() + stop_q.size() != 0) begin errors++; $display("FAIL tie_queues: %0d left required 0", arr_q.size() + stop_q.size()); end
  endtask

  task automatic test_reset_mid_move();
    int n;
    do_reset();
    cab_req = 8'h80;
    for (int f = 1; f <= 3; f++) arr_q.push_back(3'(f));
    tick(); cab_req = '0;
    n = 0;
    while (floor_o !== 3'd3 && n < 200) begin n++; tick(); end
    tick(); tick();
    checks++; if ({moving_o, floor_o, pending_o} !== {1'b1, 3'd3, 8'h80}) begin errors++; $display("FAIL mid_move: moving=%b floor=%0d pending=%h required 1 3 80", moving_o, floor_o, pending_o); end
    rst_n = 1'b0;
    #1;
    checks++; if ({floor_o, moving_o, pending_o, busy_o, dir_o} !== {3'd0, 1'b0, 8'h00, 1'b0, 2'b00}) begin errors++; $display("FAIL mid_reset: floor=%0d moving=%b pending=%h busy=%b dir=%b required 0 0 00 0 00", floor_o, moving_o, pending_o, busy_o, dir_o); end
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if ({moving_o, busy_o, floor_o} !== {1'b0, 1'b0, 3'd0}) begin errors++; $display("FAIL post_reset_idle: moving=%b busy=%b floor=%0d required 0 0 0", moving_o, busy_o, floor_o); end
    checks++; if (arr_q.size() != 0) begin errors++; $display("FAIL mid_queues: %0d arrivals left required 0", arr_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_trip();
    test_collective();
    test_door_hold();
    test_ignored_and_tie();
    test_reset_mid_move();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
